// File: rtl/bfifo_rst_pkg.sv
// Shared types and sizing helpers for the FIFO reset sequencer.
package bfifo_rst_pkg;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_ASSERT,
    ST_POST,
    ST_IDLE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bfifo_rst_sync.sv
// Two-flop reset synchroniser: asynchronous assert, synchronous release.
module bfifo_rst_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rel_pre,
  output logic o_rel
);

  logic [1:0] r_ff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ff <= '0;
    else          r_ff <= {r_ff[0], 1'b1};
  end

  assign o_rel_pre = r_ff[0];
  assign o_rel     = r_ff[1];

endmodule

// File: rtl/bfifo_rst_seq.sv
// Reset sequencer shared by NCH FIFOs: holds fifo_rst_o for RST_LEN cycles,
// keeps busy for POST_LEN more, and gates the AXI-Stream handshakes meanwhile.
module bfifo_rst_seq
  import bfifo_rst_pkg::*;
#(
  parameter int unsigned NCH      = 1,
  parameter int unsigned RST_LEN  = 5,
  parameter int unsigned POST_LEN = 2
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           soft_rst_i,
  input  logic [NCH-1:0] fifo_full_i,
  input  logic [NCH-1:0] fifo_valid_i,
  input  logic [NCH-1:0] s_axis_tvalid,
  input  logic [NCH-1:0] m_axis_tready,
  output logic           fifo_rst_o,
  output logic           rst_busy_o,
  output logic           rst_done_o,
  output logic [NCH-1:0] s_axis_tready,
  output logic [NCH-1:0] wr_en_o,
  output logic [NCH-1:0] m_axis_tvalid,
  output logic [NCH-1:0] rd_en_o
);

  localparam int unsigned CW = cnt_width(RST_LEN, POST_LEN);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_LEN - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_LEN - 1);

  if (NCH < 1 || RST_LEN < 1 || POST_LEN < 1) begin : g_param_check
    $error("bfifo_rst_seq: NCH, RST_LEN and POST_LEN must all be >= 1");
  end

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_fifo_rst;
  logic          r_busy;
  logic          r_done;
  logic          w_rel_pre;
  logic          w_rel;

  bfifo_rst_sync u_sync (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .o_rel_pre (w_rel_pre),
    .o_rel     (w_rel)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_ARM;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_fifo_rst <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // Leaves ARM on the same edge the second synchroniser stage goes high.
        ST_ARM: if (w_rel_pre) begin
          r_state    <= ST_ASSERT;
          r_fifo_rst <= 1'b1;
          r_cnt      <= '0;
        end
        ST_ASSERT: begin
          if (soft_rst_i) r_pend <= 1'b1;
          if (r_cnt == RST_LAST) begin
            r_state    <= ST_POST;
            r_fifo_rst <= 1'b0;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_POST: begin
          if (r_cnt == POST_LAST) begin
            r_cnt <= '0;
            // A request landing on the final POST cycle folds into the re-run.
            if (r_pend || soft_rst_i) begin
              r_state    <= ST_ASSERT;
              r_fifo_rst <= 1'b1;
              r_pend     <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            if (soft_rst_i) r_pend <= 1'b1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_IDLE: if (soft_rst_i && w_rel) begin
          r_state    <= ST_ASSERT;
          r_fifo_rst <= 1'b1;
          r_busy     <= 1'b1;
          r_cnt      <= '0;
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

  assign fifo_rst_o = r_fifo_rst;
  assign rst_busy_o = r_busy;
  assign rst_done_o = r_done;

  logic [NCH-1:0] w_s_tready;
  logic [NCH-1:0] w_m_tvalid;

  assign w_s_tready    = ~fifo_full_i & {NCH{~r_busy}};
  assign w_m_tvalid    = fifo_valid_i & {NCH{~r_busy}};
  assign s_axis_tready = w_s_tready;
  assign wr_en_o       = w_s_tready & s_axis_tvalid;
  assign m_axis_tvalid = w_m_tvalid;
  assign rd_en_o       = w_m_tvalid & m_axis_tready;

endmodule

// File: tb/tb_bfifo_rst_seq.sv
// Bench for bfifo_rst_seq (NCH=2, RST_LEN=5, POST_LEN=2): sequence-position model plus directed checks.
module tb_bfifo_rst_seq;

  localparam int NCH      = 2;
  localparam int RST_LEN  = 5;
  localparam int POST_LEN = 2;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           soft_rst_i;
  logic [NCH-1:0] fifo_full_i, fifo_valid_i, s_axis_tvalid, m_axis_tready;
  logic           fifo_rst_o, rst_busy_o, rst_done_o;
  logic [NCH-1:0] s_axis_tready, wr_en_o, m_axis_tvalid, rd_en_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  bfifo_rst_seq #(.NCH(NCH), .RST_LEN(RST_LEN), .POST_LEN(POST_LEN)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .soft_rst_i    (soft_rst_i),
    .fifo_full_i   (fifo_full_i),
    .fifo_valid_i  (fifo_valid_i),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_rst_o    (fifo_rst_o),
    .rst_busy_o    (rst_busy_o),
    .rst_done_o    (rst_done_o),
    .s_axis_tready (s_axis_tready),
    .wr_en_o       (wr_en_o),
    .m_axis_tvalid (m_axis_tvalid),
    .rd_en_o       (rd_en_o)
  );

  // Model: a sequence is a run of RST_LEN+POST_LEN cycles; m_pos is the position in it.
  bit m_arm, m_seen, m_inseq, m_pend, m_done;
  int m_pos;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_arm = 1; m_seen = 0; m_inseq = 0; m_pend = 0; m_done = 0; m_pos = 0;
    end else begin
      m_done = 0;
      if (m_arm) begin
        if (m_seen) begin m_arm = 0; m_inseq = 1; m_pos = 0; end
        else m_seen = 1;
      end else if (m_inseq) begin
        if (soft_rst_i) m_pend = 1;
        m_pos++;
        if (m_pos == RST_LEN + POST_LEN) begin
          if (m_pend) begin m_pos = 0; m_pend = 0; end
          else begin m_inseq = 0; m_done = 1; end
        end
      end else if (soft_rst_i) begin
        m_inseq = 1; m_pos = 0;
      end
    end
  end

  always @(negedge aclk) begin
    logic           e_busy, e_rst;
    logic [NCH-1:0] e_tr, e_mv;
    e_busy = m_arm || m_inseq;
    e_rst  = m_inseq && (m_pos < RST_LEN);
    e_tr   = ~fifo_full_i & {NCH{~e_busy}};
    e_mv   = fifo_valid_i & {NCH{~e_busy}};
    n_chk++;
    if ({fifo_rst_o, rst_busy_o, rst_done_o, s_axis_tready, wr_en_o, m_axis_tvalid, rd_en_o} !==
        {e_rst, e_busy, m_done, e_tr, e_tr & s_axis_tvalid, e_mv, e_mv & m_axis_tready}) begin
      n_fail++;
      $display("FAIL model t=%0t rst/busy/done=%b%b%b exp %b%b%b trdy=%b exp %b wr=%b exp %b tval=%b exp %b rd=%b exp %b",
               $time, fifo_rst_o, rst_busy_o, rst_done_o, e_rst, e_busy, m_done,
               s_axis_tready, e_tr, wr_en_o, e_tr & s_axis_tvalid,
               m_axis_tvalid, e_mv, rd_en_o, e_mv & m_axis_tready);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int dones;
    aresetn = 1'b0; soft_rst_i = 1'b0;
    fifo_full_i = 2'b01; fifo_valid_i = 2'b11; s_axis_tvalid = 2'b11; m_axis_tready = 2'b11;
    repeat (2) after_edge();
    chk("reset_rst",  8'(fifo_rst_o), 8'h0);
    chk("reset_busy", 8'(rst_busy_o), 8'h1);
    chk("reset_done", 8'(rst_done_o), 8'h0);
    chk("reset_trdy", 8'(s_axis_tready), 8'h0);

    // Power-on release just before edge 1.
    aresetn = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      after_edge();
      chk($sformatf("por_rst_e%0d", e),  8'(fifo_rst_o), 8'((e >= 2 && e <= 6) ? 1 : 0));
      chk($sformatf("por_busy_e%0d", e), 8'(rst_busy_o), 8'((e < 9) ? 1 : 0));
      chk($sformatf("por_done_e%0d", e), 8'(rst_done_o), 8'((e == 9) ? 1 : 0));
    end
    chk("idle_trdy", 8'(s_axis_tready), 8'h2);
    chk("idle_tval", 8'(m_axis_tvalid), 8'h3);
    chk("idle_wr",   8'(wr_en_o),       8'h2);
    chk("idle_rd",   8'(rd_en_o),       8'h3);

    // Single soft reset from IDLE, sampled at edge k (j=0).
    soft_rst_i = 1'b1;
    for (int j = 0; j <= 7; j++) begin
      after_edge();
      soft_rst_i = 1'b0;
      chk($sformatf("soft_rst_j%0d", j),  8'(fifo_rst_o), 8'((j <= 4) ? 1 : 0));
      chk($sformatf("soft_busy_j%0d", j), 8'(rst_busy_o), 8'((j < 7) ? 1 : 0));
      chk($sformatf("soft_done_j%0d", j), 8'(rst_done_o), 8'((j == 7) ? 1 : 0));
      if (j == 1) begin
        chk("busy_trdy", 8'(s_axis_tready), 8'h0);
        chk("busy_tval", 8'(m_axis_tvalid), 8'h0);
        chk("busy_wr",   8'(wr_en_o),       8'h0);
        chk("busy_rd",   8'(rd_en_o),       8'h0);
      end
    end

    // Two requests during one sequence collapse into a single re-run.
    fifo_full_i = 2'b10; fifo_valid_i = 2'b01;
    after_edge();
    soft_rst_i = 1'b1;
    dones = 0;
    for (int j = 0; j <= 16; j++) begin
      after_edge();
      soft_rst_i = (j == 2 || j == 4) ? 1'b1 : 1'b0;
      if (rst_done_o) dones++;
      chk($sformatf("rerun_rst_j%0d", j),  8'(fifo_rst_o),
          8'(((j <= 4) || (j >= 7 && j <= 11)) ? 1 : 0));
      chk($sformatf("rerun_busy_j%0d", j), 8'(rst_busy_o), 8'((j < 14) ? 1 : 0));
    end
    chk("rerun_done_count", 8'(dones), 8'h1);

    // aresetn dropped mid-POST, then a full restart.
    fifo_full_i = 2'b00; fifo_valid_i = 2'b10; s_axis_tvalid = 2'b01; m_axis_tready = 2'b10;
    soft_rst_i = 1'b1;
    after_edge();
    soft_rst_i = 1'b0;
    repeat (5) after_edge();
    chk("post_state_rst",  8'(fifo_rst_o), 8'h0);
    chk("post_state_busy", 8'(rst_busy_o), 8'h1);
    aresetn = 1'b0;
    #1;
    chk("abort_rst",  8'(fifo_rst_o), 8'h0);
    chk("abort_busy", 8'(rst_busy_o), 8'h1);
    chk("abort_done", 8'(rst_done_o), 8'h0);
    repeat (2) after_edge();
    aresetn = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      after_edge();
      chk($sformatf("restart_rst_e%0d", e),  8'(fifo_rst_o), 8'((e >= 2 && e <= 6) ? 1 : 0));
      chk($sformatf("restart_done_e%0d", e), 8'(rst_done_o), 8'((e == 9) ? 1 : 0));
    end
    chk("final_trdy", 8'(s_axis_tready), 8'h3);
    chk("final_wr",   8'(wr_en_o),       8'h1);
    chk("final_tval", 8'(m_axis_tvalid), 8'h2);
    chk("final_rd",   8'(rd_en_o),       8'h2);

    @(negedge aclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
